// File: rtl/mdu_pkg.sv
// Shared encodings for the multiply/HI-LO unit: opcodes, FSM states and opcode helpers.
package mdu_pkg;

  typedef enum logic [3:0] {
    OP_MULT  = 4'd0,
    OP_MULTU = 4'd1,
    OP_MADD  = 4'd2,
    OP_MADDU = 4'd3,
    OP_MSUB  = 4'd4,
    OP_MSUBU = 4'd5,
    OP_MUL   = 4'd6,
    OP_MTHI  = 4'd7,
    OP_MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_ACC  = 2'd2
  } mdu_state_e;

  function automatic logic op_is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_MUL);
  endfunction

  function automatic logic op_is_mul_class(input logic [3:0] op);
    return op <= OP_MUL;
  endfunction

endpackage

// File: rtl/hilo_mdu.sv
// Multiply/HI-LO unit: registers EX operands, drives the external Multiplier,
// waits out its latency and then writes, accumulates into or subtracts from HI/LO.
module hilo_mdu
  import mdu_pkg::*;
#(
  parameter int MUL_LAT = 1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_op,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic        flush,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic [31:0] mul_result,
  output logic        mul_valid,
  output logic        mul_start,
  output logic        mul_sign,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_prod
);

  localparam int CW = $clog2(MUL_LAT + 1);

  mdu_state_e    state_reg;
  logic [CW-1:0] cnt_reg;
  logic [3:0]    op_reg;
  logic [31:0]   a_reg;
  logic [31:0]   b_reg;
  logic          sign_reg;
  logic          start_reg;
  logic [31:0]   hi_reg;
  logic [31:0]   lo_reg;
  logic [31:0]   mul_result_reg;
  logic          mul_valid_reg;

  logic          accept;
  logic [63:0]   hilo_next;

  assign busy       = (state_reg != ST_IDLE);
  assign req_ready  = ~busy;
  assign accept     = req_valid & req_ready & ~flush;

  assign hi         = hi_reg;
  assign lo         = lo_reg;
  assign mul_result = mul_result_reg;
  assign mul_valid  = mul_valid_reg;
  assign mul_start  = start_reg;
  assign mul_sign   = sign_reg;
  assign mul_a      = a_reg;
  assign mul_b      = b_reg;

  // The 64-bit accumulate/subtract wraps naturally modulo 2^64.
  always_comb begin
    hilo_next = {hi_reg, lo_reg};
    case (op_reg)
      OP_MULT, OP_MULTU: hilo_next = mul_prod;
      OP_MADD, OP_MADDU: hilo_next = {hi_reg, lo_reg} + mul_prod;
      OP_MSUB, OP_MSUBU: hilo_next = {hi_reg, lo_reg} - mul_prod;
      default:           hilo_next = {hi_reg, lo_reg};
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= '0;
      op_reg         <= '0;
      a_reg          <= '0;
      b_reg          <= '0;
      sign_reg       <= 1'b0;
      start_reg      <= 1'b0;
      hi_reg         <= '0;
      lo_reg         <= '0;
      mul_result_reg <= '0;
      mul_valid_reg  <= 1'b0;
    end else begin
      start_reg     <= 1'b0;
      mul_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (accept) begin
            if (req_op == OP_MTHI) begin
              hi_reg <= req_a;
            end else if (req_op == OP_MTLO) begin
              lo_reg <= req_a;
            end else if (op_is_mul_class(req_op)) begin
              op_reg    <= req_op;
              a_reg     <= req_a;
              b_reg     <= req_b;
              sign_reg  <= op_is_signed(req_op);
              start_reg <= 1'b1;
              cnt_reg   <= CW'(MUL_LAT);
              state_reg <= ST_MUL;
            end
            // Undefined opcodes are swallowed without side effects.
          end
        end
        ST_MUL: begin
          if (flush) begin
            state_reg <= ST_IDLE;
          end else begin
            cnt_reg <= cnt_reg - CW'(1);
            if (cnt_reg == CW'(1)) begin
              state_reg <= ST_ACC;
            end
          end
        end
        ST_ACC: begin
          state_reg <= ST_IDLE;
          // A flush landing on the write edge cancels the write entirely.
          if (!flush) begin
            if (op_reg == OP_MUL) begin
              mul_result_reg <= mul_prod[31:0];
              mul_valid_reg  <= 1'b1;
            end else begin
              {hi_reg, lo_reg} <= hilo_next;
            end
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

endmodule
